// File: rtl/dws_pkg.sv
// Shared types and widths for the delayed-write scheduler.
// slot_t is one pending write: valid flag, cycles-to-go countdown and payload.
package dws_pkg;

   localparam int PKG_DW    = 32;
   localparam int PKG_DELW  = 8;
   localparam int PKG_DEPTH = 4;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   localparam int PKG_CW = cnt_w(PKG_DEPTH);

   typedef struct packed {
      logic                valid;
      logic [PKG_DELW-1:0] cnt;
      logic [PKG_DW-1:0]   data;
   } slot_t;

endpackage

// File: rtl/dws_age_matrix.sv
// Acceptance-order tracker for the pending-write slots.
// Ports: clk/rst, alloc_i (one-hot new slot), mask_i (candidates),
// youngest_o (one-hot youngest candidate, combinational from state).
module dws_age_matrix
   import dws_pkg::*;
#(
   parameter int DEPTH = PKG_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DEPTH-1:0] alloc_i,
   input  logic [DEPTH-1:0] mask_i,
   output logic [DEPTH-1:0] youngest_o
);

   // age_q[i][j] = 1 : slot i was accepted before slot j
   logic [DEPTH-1:0] age_q [DEPTH];
   logic [DEPTH-1:0] age_d [DEPTH];

   // A new slot is younger than everything; rows of freed slots may go
   // stale, harmless because only valid slots are ever in the mask.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         age_d[i] = age_q[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (alloc_i[i]) begin
               age_d[i][j] = 1'b0;
            end else if (alloc_i[j]) begin
               age_d[i][j] = 1'b1;
            end
         end
      end
   end

   // Youngest candidate: not older than any other candidate.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         youngest_o[i] = mask_i[i] & ~|(age_q[i] & mask_i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            age_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            age_q[i] <= age_d[i];
         end
      end
   end

endmodule

// File: rtl/delayed_write_sched.sv
// Cycle model of `val <= #d expr`: delayed writes held in a slot pool,
// committed last-accepted-wins. Ports: req_* handshake with delay/data,
// cancel_all, registered val/val_changed, pending_cnt occupancy.
module delayed_write_sched
   import dws_pkg::*;
#(
   parameter int          DW        = PKG_DW,
   parameter int          DELW      = PKG_DELW,
   parameter int          DEPTH     = PKG_DEPTH,
   parameter logic [DW-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [DELW-1:0]            req_delay,
   input  logic [DW-1:0]              req_data,
   input  logic                       cancel_all,
   output logic [DW-1:0]              val,
   output logic                       val_changed,
   output logic [$clog2(DEPTH+1)-1:0] pending_cnt
);

   localparam int CW = $clog2(DEPTH + 1);

   // slot_t carries the package widths, so DW/DELW track PKG_DW/PKG_DELW
   slot_t slot_q [DEPTH];
   slot_t slot_d [DEPTH];

   logic [DW-1:0]    val_q, val_d;
   logic             chg_q, chg_d;
   logic [DW-1:0]    exp_data;
   logic [CW-1:0]    cnt_c;
   logic [DEPTH-1:0] vld, expire, alloc, youngest;
   logic             accept, bypass, take, found;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         vld[i]    = slot_q[i].valid;
         expire[i] = slot_q[i].valid & (slot_q[i].cnt == DELW'(1));
      end
   end

   always_comb begin
      cnt_c = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt_c = cnt_c + CW'(vld[i]);
      end
   end

   // Ready only from registered occupancy: a slot freed this edge
   // cannot be refilled until the next one.
   assign req_ready = (cnt_c < CW'(DEPTH));
   assign accept    = req_valid & req_ready;
   assign bypass    = accept & (req_delay == '0);
   assign take      = accept & ~bypass & ~cancel_all;

   // Lowest-index slot that is free in registered state.
   always_comb begin
      alloc = '0;
      found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!vld[i] && !found) begin
            alloc[i] = take;
            found    = 1'b1;
         end
      end
   end

   dws_age_matrix #(
      .DEPTH (DEPTH)
   ) u_age (
      .clk        (clk),
      .rst        (rst),
      .alloc_i    (alloc),
      .mask_i     (expire),
      .youngest_o (youngest)
   );

   always_comb begin
      exp_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (youngest[i]) begin
            exp_data = exp_data | slot_q[i].data;
         end
      end
   end

   // Bypass was accepted last, so it beats any expiring slot.
   always_comb begin
      val_d = val_q;
      if (bypass) begin
         val_d = req_data;
      end else if (|expire && !cancel_all) begin
         val_d = exp_data;
      end
      chg_d = (val_d != val_q);
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         slot_d[i] = slot_q[i];
         if (cancel_all) begin
            slot_d[i].valid = 1'b0;
         end else if (alloc[i]) begin
            slot_d[i] = '{valid: 1'b1, cnt: req_delay, data: req_data};
         end else if (slot_q[i].valid) begin
            if (expire[i]) begin
               slot_d[i].valid = 1'b0;
            end else begin
               slot_d[i].cnt = slot_q[i].cnt - DELW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         val_q <= RESET_VAL;
         chg_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         val_q <= val_d;
         chg_q <= chg_d;
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

   assign val         = val_q;
   assign val_changed = chg_q;
   assign pending_cnt = cnt_c;

endmodule

// File: doc/delayed_write_sched.md
Name: delayed_write_sched

Overview:
- Cycle-based hardware model of intra-assignment delayed writes (`val <= #d expr`) feeding a single value register.
- Accepts write requests that carry a data value and a delay in clock cycles, and holds them in a small pending pool.
- Each request is committed to `val` when its delay expires.
- Downstream, a change monitor consumes `val_changed` as the equivalent of `always @val`.

Parameters:
- DW, 32, width of data and of `val`.
- DELW, 8, width of the request delay field.
- DEPTH, 4, number of pending-write slots (≥2).
- RESET_VAL, 0, value of `val` after reset.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  write request present.
- req_ready  out  1  high when at least one slot is free.
- req_delay  in  DELW  delay `d` in cycles.
- req_data  in  DW  value to write.
- cancel_all  in  1  drop all pending writes; `val` is unchanged.
- val  out  DW  committed value (registered).
- val_changed  out  1  one-cycle pulse after any edge at which `val` took a different value.
- pending_cnt  out  $clog2(DEPTH+1)  number of occupied slots.

Behaviour:
- Reset (async, rst=1):
  - `val`=RESET_VAL, `val_changed`=0, `pending_cnt`=0.
  - All slots invalid, age matrix cleared, `req_ready`=1.
- Acceptance:
  - A request is accepted when `req_valid & req_ready` at an edge E.
  - `req_ready` = (`pending_cnt` < DEPTH), from registered state only. A slot freed at E does not raise ready until after E.
- d=0: bypass. `val` takes `req_data` at edge E itself; no slot is consumed.
- d≥1:
  - The request occupies the lowest-index free slot with countdown=d.
  - It commits to `val` at edge E+d.
  - Each slot's countdown decrements every edge while valid. It commits and frees at the edge where countdown==1.
- Ordering:
  - An age matrix records acceptance order: age[i][j]=1 means i is older than j.
  - When several slots expire at the same edge, the youngest wins.
  - A d=0 bypass at that same edge beats every expiring slot.
  - Outcome is last-accepted-wins, matching non-blocking assignment order.
- Simultaneous accept and expiry: an accept and any number of expiries may occur on one edge. The new slot allocation must not reuse a slot freed on that same edge.
- `val_changed`: registered. It is 1 in the cycle after edge E iff `val` was updated at E with new value != old value. Writing an equal value gives no pulse.
- `cancel_all`:
  - At edge E it invalidates all slots and zeroes `pending_cnt`.
  - A request accepted at E with d≥1 is also dropped.
  - A d=0 request at E still writes `val`.
  - Slots expiring at E are discarded.
- Arithmetic:
  - Countdown is DELW bits; the maximum delay is 2^DELW−1 cycles.
  - `pending_cnt` = popcount of the valid bits, updated the same edge.
- Reset mid-operation: all pending writes are lost, and `val` returns to RESET_VAL asynchronously.

Decomposition:
- Shared package `dws_pkg`:
  - `slot_t` struct {valid, cnt[DELW], data[DW]}.
  - `clog2`-based width localparams.
- Natural sub-module `dws_age_matrix`:
  - DEPTH×DEPTH age tracking.
  - Inputs: alloc one-hot, expire mask.
  - Output: one-hot youngest-of-mask.
- The top module holds the slots, allocation priority encoder, commit mux and change detect.

Test Plan:
- Reset, then d=0 writes of 1 then 2 on consecutive cycles → `val`=1 then 2; `val_changed` pulses in both following cycles.
- `val`=2; accept data=3 d=10 at cycle 0, then data=4 d=5 at cycle 1 → `val`=4 after edge 6, `val`=3 after edge 10; `pending_cnt` goes 1,2,…,1,0.
- Collision: data=5 d=4 at cycle 0 and data=6 d=3 at cycle 1 (both expire at edge 4), plus a d=0 data=7 at edge 4 → `val`=7; without the bypass → `val`=6.
- Fill DEPTH=4 slots with d=20 → `req_ready`=0 and a fifth request is held. At the first expiry edge `req_ready` stays 0, then rises the next cycle.
- Write equal value: `val`=9, request data=9 d=2 → no `val_changed` pulse.
- `cancel_all` with 3 pending plus a d=0 data=8 at the same edge → `pending_cnt`=0, `val`=8, no later commits. Then assert rst mid-operation → `val`=RESET_VAL immediately, with no clock edge needed.
